// File: rtl/mc_shift_if.sv
// Request/response bundle between the control unit and the multi-cycle shifter.
// The control unit drives the master side. The shifter takes the slave side.
interface mc_shift_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mc_shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL by a variable amount, at most STEP
// bit positions per clock, with valid/ready handshakes on both sides.
module mc_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  mc_shift_if.slave   bus,
  output logic        busy
);
  localparam int SHAMT_W = $clog2(WIDTH);
  // One extra bit so that a step of STEP == WIDTH is still representable.
  localparam int AMT_W   = SHAMT_W + 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   data_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_valid_q;

  logic [AMT_W-1:0]   step_amt;
  logic [SHAMT_W-1:0] rem_d;
  logic [WIDTH-1:0]   data_d;

  // Shift amount for this cycle: min(STEP, remaining) and the count left afterwards.
  always_comb begin
    step_amt = {1'b0, rem_q};
    if ({1'b0, rem_q} > AMT_W'(STEP)) begin
      step_amt = AMT_W'(STEP);
    end
    rem_d = rem_q - step_amt[SHAMT_W-1:0];
  end

  // One partial shift of the working register using the op latched at acceptance.
  // SRA keeps the sign because bit WIDTH-1 never changes across SRA steps.
  always_comb begin
    data_d = data_q;
    case (op_q)
      OP_SLL: data_d = data_q << step_amt;
      OP_SRL: data_d = data_q >> step_amt;
      OP_SRA: data_d = $signed(data_q) >>> step_amt;
      OP_ROL: data_d = (data_q << step_amt) | (data_q >> (AMT_W'(WIDTH) - step_amt));
      default: data_d = data_q;
    endcase
  end

  // Control FSM with registered result outputs. Flush overrides everything but reset.
  // The result registers load on the first DONE cycle. This adds one cycle of latency
  // and keeps out_valid/out_data glitch-free while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      op_q        <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            data_q  <= bus.in_data;
            op_q    <= bus.in_op;
            rem_q   <= bus.in_shamt;
            state_q <= (bus.in_shamt == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          data_q <= data_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= data_q;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != S_IDLE);
endmodule
